y86_fetch_seq: RTL and testbench
================================

# y86_fetch_seq

Sequential Y86-64 fetch unit: the producer side of the decode/writeback register file. It reads instruction bytes one at a time from a byte-wide instruction memory over a req/ack handshake. It assembles each instruction into icode/ifun/rA/rB/valC/valP and presents the result to decode over a valid/ready handshake. The PC-update stage supplies the next PC.

## Interface
Parameters:
- RESET_PC, 64'd0, PC value loaded on reset.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset_n  in  1  reset, asynchronous and active-low.
- imem_req  out  1  byte read request.
- imem_addr  out  64  byte address; stable while imem_req high.
- imem_ack  in  1  byte returned this cycle.
- imem_data  in  8  returned byte; valid when imem_ack.
- imem_err  in  1  address fault; qualified by imem_ack.
- pc_load  in  1  next PC available.
- pc_next  in  64  next PC from PC-update stage.
- out_valid  out  1  fetched instruction presented.
- out_ready  in  1  decode accepts.
- icode, ifun  out  4 each  instruction code and function.
- rA, rB  out  4 each  register IDs; 4'hF when no register byte.
- valC  out  64  constant, little-endian assembled; 0 when absent.
- valP  out  64  PC + instruction length.
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.

## Operation
- Instruction lengths by icode: 0 halt=1, 1 nop=1, 2 cmovXX=2, 3 irmovq=10, 4 rmmovq=10, 5 mrmovq=10, 6 OPq=2, 7 jXX=9, 8 call=9, 9 ret=1, A pushq=2, B popq=2. icode>B is invalid.
- Byte 0 holds {icode,ifun}. The register byte, if present, holds {rA,rB}. valC bytes follow, least significant first. jXX and call have no register byte.
- FSM states:
  - F_OP: request byte at PC.
    - On ack, latch icode/ifun.
    - Invalid icode: go to DONE with stat=INS.
    - Length 1: go to DONE.
    - Otherwise go to F_REG or F_CONST.
  - F_REG: request PC+1. On ack, latch rA/rB, then go to F_CONST if a constant is needed, else DONE.
  - F_CONST: 3-bit byte counter k=0..7. Request PC+off+k, where off=2 if a register byte is present, else 1. On each ack, write imem_data into valC[8k+7:8k]. After k=7, go to DONE.
  - DONE: out_valid=1, outputs held stable.
    - On out_valid&&out_ready: AOK goes to WAIT_PC; HLT/ADR/INS go to STOPPED.
  - WAIT_PC: on pc_load, PC←pc_next and go to F_OP.
  - STOPPED: absorbing until reset. imem_req=0, out_valid=0, stat holds the final code.
- imem_err with ack in any fetch state: abort the instruction and go to DONE with stat=ADR. Fields already latched are kept. valP=PC.
- halt (icode 0) is delivered with stat=HLT.
- pc_load in DONE and out handshake in the same cycle: accept both, load PC, go straight to F_OP.
- pc_load in DONE without the handshake: capture pc_next into a pending register; WAIT_PC then consumes it in zero cycles.
- pc_load in any fetch state: ignored.
- Each new instruction clears valC to 0 and sets rA/rB to 4'hF in F_OP.

## Timing
- Reset values:
  - PC=RESET_PC, state F_OP.
  - imem_req=1 (starts fetching right after reset).
  - imem_addr=RESET_PC, out_valid=0.
  - icode=ifun=0, rA=rB=4'hF, valC=0, valP=0, stat=1.
- imem handshake:
  - imem_req stays high with a stable address until the cycle imem_ack is sampled.
  - The next address appears the following cycle; req may stay high.
  - Zero-wait memory (ack every cycle) gives one byte per cycle.
- Latency with zero-wait memory: an N-byte instruction takes N cycles from the first request to out_valid=1 in cycle N+1.
- Wait states stretch latency one cycle per stalled byte.
- valP is computed from the latched PC plus length (64-bit wrap-around, no error).
- Byte addresses wrap modulo 2^64.
- Reset asserted mid-fetch or in DONE: everything returns to reset values immediately. A partially fetched instruction is discarded.

## Structure
- Shared package y86_pkg:
  - icode constants (I_HALT..I_POPQ).
  - stat codes (STAT_AOK/HLT/ADR/INS).
  - REG_NONE=4'hF.
  - FSM state enum.
- Sub-module y86_instr_len: combinational, icode → {valid, need_regs, need_valC, length[3:0]}. It is reused later by a pipelined fetch.

## Test plan
- irmovq $0x0123456789ABCDEF,%rbx at PC 0, zero-wait memory:
  - bytes 30 F3 EF CD AB 89 67 45 23 01.
  - Expected: icode=3, rA=F, rB=3, valC=0x0123456789ABCDEF, valP=10, stat=1.
  - out_valid rises on cycle 11.
- call 0x40 at PC 0x100 with 2 wait cycles per byte:
  - Expected: rA=rB=F, valC=0x40, valP=0x109.
  - out_valid held through 3 cycles of out_ready=0 with outputs stable.
- Sequence addq %rcx,%rdx (60 12) then halt (00), pc_next=0x2 loaded in the same cycle as the handshake:
  - first instruction: ifun=0, rA=1, rB=2, valP=2.
  - second instruction: stat=2.
  - Then STOPPED with imem_req=0.
- Byte 0xC0 at PC 0x20: stat=4, valP=0x20, out_valid=1, then STOPPED after the handshake.
- imem_err on the 5th byte of rmmovq: stat=3, valP=PC. Reset_n pulsed low mid-F_CONST returns all outputs to reset values with imem_addr=RESET_PC.

Source files
------------

// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared Y86-64 definitions for the fetch logic:
//   - icode constants (I_HALT .. I_POPQ)
//   - status codes (STAT_AOK/HLT/ADR/INS)
//   - REG_NONE, the register ID shown when an instruction has no register byte
//   - fetch_state_e, the state encoding of the sequential fetch FSM
// ---------------------------------------------------------------------------
package y86_pkg;

  // Instruction codes (upper nibble of byte 0).
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Status codes reported with each fetched instruction.
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Register ID meaning "no register".
  localparam logic [3:0] REG_NONE = 4'hF;

  // Sequential fetch FSM states.
  typedef enum logic [2:0] {
    F_OP,      // fetch byte 0 {icode, ifun}
    F_REG,     // fetch register byte {rA, rB}
    F_CONST,   // fetch 8 constant bytes, least significant first
    DONE,      // instruction presented to decode
    WAIT_PC,   // waiting for the PC-update stage
    STOPPED    // absorbing after HLT/ADR/INS until reset
  } fetch_state_e;

endpackage

// File: rtl/y86_instr_len.sv
// ---------------------------------------------------------------------------
// y86_instr_len
// Combinational instruction-format decoder for Y86-64. Maps an icode to the
// instruction's shape. Shared by the sequential fetch and a later pipelined
// fetch, so it carries no state.
//
// Ports:
//   i_icode      in  4  instruction code
//   o_valid      out 1  icode is a defined instruction (0..B)
//   o_need_regs  out 1  instruction carries a {rA,rB} register byte
//   o_need_valc  out 1  instruction carries an 8-byte constant
//   o_length     out 4  total instruction length in bytes (0 when invalid)
// ---------------------------------------------------------------------------
module y86_instr_len
  import y86_pkg::*;
(
  input  logic [3:0] i_icode,
  output logic       o_valid,
  output logic       o_need_regs,
  output logic       o_need_valc,
  output logic [3:0] o_length
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned; an unassigned path in combinational logic infers a latch.
    o_valid     = 1'b1;
    o_need_regs = 1'b0;
    o_need_valc = 1'b0;
    o_length    = 4'd1;
    case (i_icode)
      I_HALT, I_NOP, I_RET: begin
        o_length = 4'd1;
      end
      I_CMOVXX, I_OPQ, I_PUSHQ, I_POPQ: begin
        o_need_regs = 1'b1;
        o_length    = 4'd2;
      end
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        o_need_regs = 1'b1;
        o_need_valc = 1'b1;
        o_length    = 4'd10;
      end
      I_JXX, I_CALL: begin
        o_need_valc = 1'b1;
        o_length    = 4'd9;
      end
      default: begin
        o_valid  = 1'b0;
        o_length = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/y86_fetch_seq.sv
// ---------------------------------------------------------------------------
// y86_fetch_seq
// Sequential Y86-64 fetch unit. Reads instruction bytes one per handshake from
// a byte-wide instruction memory, assembles icode/ifun/rA/rB/valC/valP and
// presents them to decode over valid/ready. The PC-update stage supplies the
// next PC through pc_load/pc_next.
//
// Parameters:
//   RESET_PC   PC loaded on reset
//
// Ports:
//   Clk        in  1   clock, rising edge
//   Reset_n    in  1   asynchronous active-low reset
//   imem_req   out 1   byte read request
//   imem_addr  out 64  byte address, stable while imem_req is high
//   imem_ack   in  1   byte returned this cycle
//   imem_data  in  8   returned byte
//   imem_err   in  1   address fault, qualified by imem_ack
//   pc_load    in  1   next PC available
//   pc_next    in  64  next PC
//   out_valid  out 1   fetched instruction presented
//   out_ready  in  1   decode accepts
//   icode/ifun out 4   instruction code / function
//   rA/rB      out 4   register IDs, REG_NONE when absent
//   valC       out 64  little-endian constant, 0 when absent
//   valP       out 64  PC + length (PC itself on ADR/INS)
//   stat       out 3   AOK/HLT/ADR/INS
// ---------------------------------------------------------------------------
module y86_fetch_seq
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd0
)
(
  input  logic        Clk,
  input  logic        Reset_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [7:0]  imem_data,
  input  logic        imem_err,
  input  logic        pc_load,
  input  logic [63:0] pc_next,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [2:0]  stat
);

  fetch_state_e r_state;
  logic [63:0]  r_pc;
  logic [3:0]   r_icode;
  logic [3:0]   r_ifun;
  logic [3:0]   r_ra;
  logic [3:0]   r_rb;
  logic [63:0]  r_valc;
  logic [63:0]  r_valp;
  logic [2:0]   r_stat;
  logic [2:0]   r_k;          // constant byte index within F_CONST
  logic         r_pend_valid; // next PC arrived while decode was still busy
  logic [63:0]  r_pend_pc;

  logic [3:0]   w_len_icode;
  logic         w_valid;
  logic         w_need_regs;
  logic         w_need_valc;
  logic [3:0]   w_len;
  logic [63:0]  w_len_ext;
  logic [63:0]  w_off;
  logic         w_hs;

  // In F_OP the icode is still on the memory bus; afterwards it is latched.
  assign w_len_icode = (r_state == F_OP) ? imem_data[7:4] : r_icode;

  y86_instr_len u_len (
    .i_icode     (w_len_icode),
    .o_valid     (w_valid),
    .o_need_regs (w_need_regs),
    .o_need_valc (w_need_valc),
    .o_length    (w_len)
  );

  assign w_len_ext = {60'd0, w_len};
  // First constant byte sits right after the register byte, if any.
  assign w_off     = w_need_regs ? 64'd2 : 64'd1;

  assign imem_req  = (r_state == F_OP) || (r_state == F_REG) || (r_state == F_CONST);
  assign out_valid = (r_state == DONE);
  assign w_hs      = out_valid && out_ready;

  always_comb begin
    imem_addr = r_pc;
    case (r_state)
      F_REG:   imem_addr = r_pc + 64'd1;
      F_CONST: imem_addr = r_pc + w_off + {61'd0, r_k};
      default: imem_addr = r_pc;
    endcase
  end

  assign icode = r_icode;
  assign ifun  = r_ifun;
  assign rA    = r_ra;
  assign rB    = r_rb;
  assign valC  = r_valc;
  assign valP  = r_valp;
  assign stat  = r_stat;

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= F_OP;
      r_pc         <= RESET_PC;
      r_icode      <= I_HALT;
      r_ifun       <= 4'd0;
      r_ra         <= REG_NONE;
      r_rb         <= REG_NONE;
      r_valc       <= 64'd0;
      r_valp       <= 64'd0;
      r_stat       <= STAT_AOK;
      r_k          <= 3'd0;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= 64'd0;
    end else begin
      case (r_state)
        F_OP: begin
          if (imem_ack) begin
            // A new instruction starts from a clean slate.
            r_valc <= 64'd0;
            r_ra   <= REG_NONE;
            r_rb   <= REG_NONE;
            r_k    <= 3'd0;
            if (imem_err) begin
              r_icode <= I_HALT;
              r_ifun  <= 4'd0;
              r_stat  <= STAT_ADR;
              r_valp  <= r_pc;
              r_state <= DONE;
            end else begin
              r_icode <= imem_data[7:4];
              r_ifun  <= imem_data[3:0];
              if (!w_valid) begin
                r_stat  <= STAT_INS;
                r_valp  <= r_pc;
                r_state <= DONE;
              end else if (w_need_regs) begin
                r_state <= F_REG;
              end else if (w_need_valc) begin
                r_state <= F_CONST;
              end else begin
                r_stat  <= (imem_data[7:4] == I_HALT) ? STAT_HLT : STAT_AOK;
                r_valp  <= r_pc + w_len_ext;
                r_state <= DONE;
              end
            end
          end
        end

        F_REG: begin
          if (imem_ack) begin
            if (imem_err) begin
              r_stat  <= STAT_ADR;
              r_valp  <= r_pc;
              r_state <= DONE;
            end else begin
              r_ra <= imem_data[7:4];
              r_rb <= imem_data[3:0];
              if (w_need_valc) begin
                r_state <= F_CONST;
              end else begin
                r_stat  <= STAT_AOK;
                r_valp  <= r_pc + w_len_ext;
                r_state <= DONE;
              end
            end
          end
        end

        F_CONST: begin
          if (imem_ack) begin
            if (imem_err) begin
              r_stat  <= STAT_ADR;
              r_valp  <= r_pc;
              r_state <= DONE;
            end else begin
              r_valc[{r_k, 3'b000} +: 8] <= imem_data;
              if (r_k == 3'd7) begin
                r_stat  <= STAT_AOK;
                r_valp  <= r_pc + w_len_ext;
                r_state <= DONE;
              end else begin
                r_k <= r_k + 3'd1;
              end
            end
          end
        end

        DONE: begin
          if (w_hs) begin
            r_pend_valid <= 1'b0;
            if (r_stat != STAT_AOK) begin
              r_state <= STOPPED;
            end else if (pc_load) begin
              r_pc    <= pc_next;
              r_state <= F_OP;
            end else if (r_pend_valid) begin
              // The captured PC is consumed without a WAIT_PC cycle.
              r_pc    <= r_pend_pc;
              r_state <= F_OP;
            end else begin
              r_state <= WAIT_PC;
            end
          end else if (pc_load) begin
            r_pend_valid <= 1'b1;
            r_pend_pc    <= pc_next;
          end
        end

        WAIT_PC: begin
          if (pc_load) begin
            r_pc    <= pc_next;
            r_state <= F_OP;
          end
        end

        STOPPED: begin
          r_state <= STOPPED;
        end

        default: begin
          r_state <= F_OP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_y86_fetch_seq.sv
// ---------------------------------------------------------------------------
// tb_y86_fetch_seq
// Self-checking bench for y86_fetch_seq. A byte memory with configurable wait
// states answers the fetch requests; a reference function walks the bytes of
// an instruction straight from the Y86-64 encoding rules to predict each
// fetched result.
// ---------------------------------------------------------------------------
module tb_y86_fetch_seq;

  localparam logic [63:0] RESET_PC = 64'h0;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [2:0]  stat;
  } out_t;

  localparam out_t RST_OUT = '{4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1};

  logic        Clk;
  logic        Reset_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [7:0]  imem_data;
  logic        imem_err;
  logic        pc_load;
  logic [63:0] pc_next;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP;
  logic [2:0]  stat;

  out_t obs;
  assign obs = {icode, ifun, rA, rB, valC, valP, stat};

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [logic [63:0]];
  int          wait_states;
  bit          err_en;
  logic [63:0] err_addr;

  // Instruction length by icode; 0 marks an invalid icode.
  int len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 0, 0, 0, 0};

  y86_fetch_seq #(.RESET_PC(RESET_PC)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .imem_err  (imem_err),
    .pc_load   (pc_load),
    .pc_next   (pc_next),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .icode     (icode),
    .ifun      (ifun),
    .rA        (rA),
    .rB        (rB),
    .valC      (valC),
    .valP      (valP),
    .stat      (stat)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [7:0] rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic bit faulty(input logic [63:0] a);
    return err_en && (a == err_addr);
  endfunction

  // Reference: decode the instruction at pc directly from its byte encoding.
  function automatic out_t ref_fetch(input logic [63:0] pc);
    out_t        r;
    logic [7:0]  b;
    logic [63:0] a;
    bit          has_reg, has_c;
    r = '{4'h0, 4'h0, 4'hF, 4'hF, 64'h0, pc, 3'd3};
    if (faulty(pc)) return r;
    b = rd(pc);
    r.icode = b[7:4];
    r.ifun  = b[3:0];
    if (len_tab[r.icode] == 0) begin
      r.stat = 3'd4;
      return r;
    end
    has_reg = r.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    has_c   = r.icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
    a = pc + 64'd1;
    if (has_reg) begin
      if (faulty(a)) return r;
      b = rd(a);
      r.ra = b[7:4];
      r.rb = b[3:0];
      a = a + 64'd1;
    end
    if (has_c) begin
      for (int k = 0; k < 8; k++) begin
        if (faulty(a)) return r;
        r.valc[8*k +: 8] = rd(a);
        a = a + 64'd1;
      end
    end
    r.valp = pc + 64'(len_tab[r.icode]);
    r.stat = (r.icode == 4'h0) ? 3'd2 : 3'd1;
    return r;
  endfunction

  // Memory responder: each byte is acked after wait_states idle cycles.
  initial begin : responder
    int cnt;
    bit prev_req;
    cnt       = 0;
    prev_req  = 1'b0;
    imem_ack  = 1'b0;
    imem_data = 8'h00;
    imem_err  = 1'b0;
    forever begin
      @(posedge Clk);
      #2;
      if (!Reset_n || !prev_req || imem_ack) cnt = 0;
      else cnt++;
      prev_req  = imem_req;
      imem_ack  = imem_req && (cnt >= wait_states);
      imem_data = rd(imem_addr);
      imem_err  = imem_ack && faulty(imem_addr);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Places n bytes at addr; v holds them in memory order, first byte leftmost.
  task automatic put(input logic [63:0] addr, input int n, input logic [79:0] v);
    for (int i = 0; i < n; i++) mem[addr + 64'(i)] = v[8*(n-1-i) +: 8];
  endtask

  task automatic do_reset(input int ws);
    Reset_n     = 1'b0;
    out_ready   = 1'b0;
    pc_load     = 1'b0;
    pc_next     = 64'h0;
    wait_states = ws;
    tick();
    tick();
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic wait_valid(input int max_cycles, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < max_cycles) begin
      tick();
      n++;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    mem.delete();
    err_en      = 1'b0;
    Reset_n     = 1'b0;
    out_ready   = 1'b0;
    pc_load     = 1'b0;
    pc_next     = 64'h0;
    wait_states = 0;
    tick();
    checks++;
    if (obs !== RST_OUT) begin
      errors++;
      $display("FAIL reset_fields: got %h exp %h", obs, RST_OUT);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: got req=%b addr=%h valid=%b exp req=1 addr=%h valid=0",
               imem_req, imem_addr, out_valid, RESET_PC);
    end
  endtask

  task automatic test_irmovq();
    int   n;
    bit   ok;
    out_t exp;
    mem.delete();
    err_en = 1'b0;
    put(64'h0, 10, 80'h30F3EFCDAB8967452301);
    do_reset(0);
    wait_valid(50, n, ok);
    checks++;
    if (!ok || n != 10) begin
      errors++;
      $display("FAIL irmovq_latency: got ok=%0d edges=%0d exp edges=10", ok, n);
    end
    exp = '{4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 64'd10, 3'd1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL irmovq_fields: got %h exp %h", obs, exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL irmovq_wait_pc: got valid=%b req=%b exp 0 0", out_valid, imem_req);
    end
  endtask

  task automatic test_call_wait();
    int   n;
    bit   ok;
    out_t exp;
    mem.delete();
    err_en = 1'b0;
    put(64'h0, 1, 80'h10);
    put(64'h100, 9, 80'h804000000000000000);
    do_reset(2);
    wait_valid(50, n, ok);
    checks++;
    if (!ok || n != 3) begin
      errors++;
      $display("FAIL nop_wait_latency: got ok=%0d edges=%0d exp edges=3", ok, n);
    end
    out_ready = 1'b1;
    pc_load   = 1'b1;
    pc_next   = 64'h100;
    tick();
    out_ready = 1'b0;
    pc_load   = 1'b0;
    // A PC offered while fetching must not disturb the fetch.
    tick();
    pc_load = 1'b1;
    pc_next = 64'hDEAD;
    tick();
    pc_load = 1'b0;
    wait_valid(100, n, ok);
    checks++;
    if (!ok || n + 2 != 27) begin
      errors++;
      $display("FAIL call_wait_latency: got ok=%0d edges=%0d exp edges=27", ok, n + 2);
    end
    exp = '{4'h8, 4'h0, 4'hF, 4'hF, 64'h40, 64'h109, 3'd1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL call_fields: got %h exp %h", obs, exp);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || obs !== exp) begin
        errors++;
        $display("FAIL call_hold%0d: got valid=%b %h exp valid=1 %h", i, out_valid, obs, exp);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int   n;
    bit   ok;
    out_t exp;
    mem.delete();
    err_en = 1'b0;
    put(64'h0, 3, 80'h601200);
    do_reset(0);
    wait_valid(20, n, ok);
    exp = '{4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'd2, 3'd1};
    checks++;
    if (!ok || obs !== exp) begin
      errors++;
      $display("FAIL addq_fields: got ok=%0d %h exp %h", ok, obs, exp);
    end
    out_ready = 1'b1;
    pc_load   = 1'b1;
    pc_next   = 64'h2;
    tick();
    out_ready = 1'b0;
    pc_load   = 1'b0;
    wait_valid(20, n, ok);
    exp = '{4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'd3, 3'd2};
    checks++;
    if (!ok || n != 1 || obs !== exp) begin
      errors++;
      $display("FAIL halt_fields: got ok=%0d edges=%0d %h exp edges=1 %h", ok, n, obs, exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0 || stat !== 3'd2) begin
      errors++;
      $display("FAIL halt_stopped: got req=%b valid=%b stat=%0d exp 0 0 2", imem_req, out_valid, stat);
    end
    pc_load = 1'b1;
    pc_next = 64'h0;
    tick();
    tick();
    pc_load = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0 || stat !== 3'd2) begin
      errors++;
      $display("FAIL halt_absorbing: got req=%b valid=%b stat=%0d exp 0 0 2", imem_req, out_valid, stat);
    end
  endtask

  task automatic test_invalid();
    int   n;
    bit   ok;
    out_t exp;
    mem.delete();
    err_en = 1'b0;
    put(64'h0, 1, 80'h10);
    put(64'h20, 1, 80'hC0);
    do_reset(1);
    wait_valid(20, n, ok);
    // PC arrives while decode is not ready: held pending until the handshake.
    pc_load = 1'b1;
    pc_next = 64'h20;
    tick();
    pc_load = 1'b0;
    pc_next = 64'h0;
    checks++;
    if (out_valid !== 1'b1 || valP !== 64'h1) begin
      errors++;
      $display("FAIL pending_hold: got valid=%b valP=%h exp valid=1 valP=1", out_valid, valP);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_valid(20, n, ok);
    exp = '{4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h20, 3'd4};
    checks++;
    if (!ok || n != 2 || obs !== exp) begin
      errors++;
      $display("FAIL invalid_fields: got ok=%0d edges=%0d %h exp edges=2 %h", ok, n, obs, exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0 || stat !== 3'd4) begin
      errors++;
      $display("FAIL invalid_stopped: got req=%b valid=%b stat=%0d exp 0 0 4", imem_req, out_valid, stat);
    end
  endtask

  task automatic test_adr_reset();
    int   n;
    bit   ok;
    out_t exp;
    mem.delete();
    put(64'h0, 10, 80'h40121122334455667788);
    err_en   = 1'b1;
    err_addr = 64'h4;
    do_reset(0);
    wait_valid(20, n, ok);
    exp = '{4'h4, 4'h0, 4'h1, 4'h2, 64'h2211, 64'h0, 3'd3};
    checks++;
    if (!ok || n != 5 || obs !== exp) begin
      errors++;
      $display("FAIL adr_fields: got ok=%0d edges=%0d %h exp edges=5 %h", ok, n, obs, exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0 || stat !== 3'd3) begin
      errors++;
      $display("FAIL adr_stopped: got req=%b valid=%b stat=%0d exp 0 0 3", imem_req, out_valid, stat);
    end
    // Restart and pull reset in the middle of the constant bytes.
    err_en = 1'b0;
    do_reset(0);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (imem_addr !== 64'h4 || icode !== 4'h4) begin
      errors++;
      $display("FAIL mid_const_addr: got addr=%h icode=%h exp addr=4 icode=4", imem_addr, icode);
    end
    #2;
    Reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== RST_OUT || imem_addr !== RESET_PC || imem_req !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got %h addr=%h req=%b valid=%b exp %h addr=%h req=1 valid=0",
               obs, imem_addr, imem_req, out_valid, RST_OUT, RESET_PC);
    end
    do_reset(0);
    wait_valid(20, n, ok);
    exp = ref_fetch(64'h0);
    checks++;
    if (!ok || n != 10 || obs !== exp) begin
      errors++;
      $display("FAIL refetch_after_reset: got ok=%0d edges=%0d %h exp edges=10 %h", ok, n, obs, exp);
    end
  endtask

  task automatic test_random();
    int          n, stall, mode;
    bit          ok;
    logic [63:0] cur_pc, nxt;
    logic [3:0]  ic;
    out_t        exp, snap;
    mem.delete();
    err_en = 1'b0;
    put(64'h0, 1, 80'h10);
    do_reset(0);
    cur_pc = 64'h0;
    for (int it = 0; it < 40; it++) begin
      wait_valid(100, n, ok);
      exp = ref_fetch(cur_pc);
      checks++;
      if (!ok || obs !== exp) begin
        errors++;
        $display("FAIL rand_fetch%0d: got ok=%0d %h exp %h", it, ok, obs, exp);
      end
      // Next instruction: random address, sometimes straddling the 2^64 wrap.
      if ($urandom_range(0, 3) == 0) nxt = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
      else                          nxt = {$urandom, $urandom};
      ic = 4'($urandom_range(1, 11));
      mem[nxt] = {ic, 4'($urandom_range(0, 15))};
      for (int i = 1; i < 10; i++) mem[nxt + 64'(i)] = 8'($urandom);
      wait_states = $urandom_range(0, 2);
      snap  = obs;
      stall = $urandom_range(0, 2);
      for (int s = 0; s < stall; s++) begin
        tick();
        checks++;
        if (out_valid !== 1'b1 || obs !== snap) begin
          errors++;
          $display("FAIL rand_hold%0d: got valid=%b %h exp valid=1 %h", it, out_valid, obs, snap);
        end
      end
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        out_ready = 1'b1;
        pc_load   = 1'b1;
        pc_next   = nxt;
        tick();
        out_ready = 1'b0;
        pc_load   = 1'b0;
      end else if (mode == 1) begin
        pc_load = 1'b1;
        pc_next = nxt;
        tick();
        pc_load   = 1'b0;
        pc_next   = 64'h0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
      end else begin
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
        pc_load = 1'b1;
        pc_next = nxt;
        tick();
        pc_load = 1'b0;
      end
      cur_pc = nxt;
    end
  endtask

  initial begin
    Reset_n     = 1'b0;
    out_ready   = 1'b0;
    pc_load     = 1'b0;
    pc_next     = 64'h0;
    wait_states = 0;
    err_en      = 1'b0;
    err_addr    = 64'h0;
    test_reset();
    test_irmovq();
    test_call_wait();
    test_back_to_back();
    test_invalid();
    test_adr_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
